// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial character receiver.
// Pure declarations: no latency, no flow control.
package serial_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a parameterised reset value.
// Latency 2 clk; no backpressure.
module rx_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic q_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q_out = sync2_q;

endmodule

// File: rtl/serial_char_rx.sv
// 8N1 serial receiver with sticky status flags (received / frame error / overrun) for a CPU port.
// Flags update on the stop-bit sample edge; rx_ack only clears flags and never stalls reception.
module serial_char_rx
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] char_data,
    output logic                 char_received,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int                TICK_W    = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic rx_sync;

    rx_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (rx_serial),
        .q_out   (rx_sync)
    );

    rx_state_t            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] char_data_q, char_data_d;
    logic                 char_received_q, char_received_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_prev_q, rx_prev_d;

    always_comb begin
        state_d         = state_q;
        tick_d          = tick_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rx_prev_d       = rx_sync;
        char_data_d     = char_data_q;
        // Acknowledge clears first; a completion in the same cycle overrides below.
        char_received_d = rx_ack ? 1'b0 : char_received_q;
        frame_error_d   = rx_ack ? 1'b0 : frame_error_q;
        overrun_d       = rx_ack ? 1'b0 : overrun_q;

        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync) begin
                    state_d   = START;
                    tick_d    = '0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (tick_q == HALF_TICK) begin
                    tick_d  = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_q == FULL_TICK) begin
                    tick_d  = '0;
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_q == FULL_TICK) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (rx_sync) begin
                        char_data_d     = shift_q;
                        char_received_d = 1'b1;
                        if (char_received_q && !rx_ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            tick_q          <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            char_data_q     <= '0;
            char_received_q <= 1'b0;
            frame_error_q   <= 1'b0;
            overrun_q       <= 1'b0;
            rx_prev_q       <= 1'b1;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            char_data_q     <= char_data_d;
            char_received_q <= char_received_d;
            frame_error_q   <= frame_error_d;
            overrun_q       <= overrun_d;
            rx_prev_q       <= rx_prev_d;
        end
    end

    assign char_data     = char_data_q;
    assign char_received = char_received_q;
    assign frame_error   = frame_error_q;
    assign overrun       = overrun_q;

endmodule

// File: doc/serial_char_rx.md
SERIAL_CHAR_RX -- requirements
Module: serial_char_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port rx_serial, input, 1 bit: asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 The block SHALL have port rx_ack, input, 1 bit: level from the CPU output port; high clears the status flags.
REQ-006 The block SHALL have port char_data, output, 8 bits: last correctly framed character.
REQ-007 The block SHALL have port char_received, output, 1 bit: character available; drives the CPU "character received" input port.
REQ-008 The block SHALL have port frame_error, output, 1 bit: sticky flag set by a bad stop bit.
REQ-009 The block SHALL have port overrun, output, 1 bit: sticky flag set when a character is lost unread.

Function
REQ-010 rx_serial SHALL pass through a 2-flop synchronizer; all downstream logic SHALL use only the synchronized value.
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP; it resets to IDLE.
REQ-012 In IDLE, a synchronized high-to-low transition SHALL clear the bit counter and tick counter and move the FSM to START.
REQ-013 In START, at tick CLKS_PER_BIT/2-1 (mid-bit), the line SHALL be sampled: low moves to DATA; high is a glitch and returns to IDLE with no flag change.
REQ-014 In DATA, the line SHALL be sampled every CLKS_PER_BIT cycles; the value SHALL shift into an 8-bit register LSB-first; after bit 7 the FSM moves to STOP.
REQ-015 In STOP, the line SHALL be sampled one CLKS_PER_BIT after bit 7; the FSM then returns to IDLE on the next cycle.
REQ-016 A good stop bit (sampled 1) SHALL load char_data from the shift register and set char_received on the next cycle.
REQ-017 A bad stop bit (sampled 0) SHALL leave char_data and char_received unchanged and set frame_error.
REQ-018 A good stop bit while char_received is already 1 SHALL overwrite char_data and set overrun.
REQ-019 rx_ack=1 SHALL clear char_received, frame_error and overrun on the next cycle; char_data SHALL hold its value.
REQ-020 If a good-stop completion and rx_ack=1 occur in the same cycle, completion SHALL win: char_received=1, new char_data loaded, overrun not set.
REQ-021 Reception SHALL continue independently of rx_ack; a held-high rx_ack SHALL NOT block reception.
REQ-022 The tick counter width SHALL be $clog2(CLKS_PER_BIT); the bit counter SHALL be 3 bits and SHALL NOT wrap beyond bit 7.
REQ-023 The FSM SHALL NOT re-arm in STOP; a line low after the stop sample SHALL be detected only in IDLE as a new falling edge.

Reset
REQ-024 On reset_n=0, the block SHALL asynchronously set the FSM to IDLE, clear all counters, the shift register, char_data, char_received, frame_error and overrun to 0, and set both synchronizer flops to 1.
REQ-025 A reset mid-frame SHALL abort the frame with no flag set; after release, reception SHALL resume only from a new falling edge.

Structure
REQ-026 Package serial_rx_pkg SHALL hold the state enum type rx_state_t and the constant DATA_BITS=8.
REQ-027 The synchronizer SHALL be a sub-module named rx_sync2: 2 flops, reset value parameterised, set to 1 here.
REQ-028 The FSM, counters, shift register and flags SHALL reside in serial_char_rx.

Verification (CLKS_PER_BIT=16, cycle 0 = rx_serial falling edge)
REQ-029 Send 0x41 with a good stop bit -> char_received rises at cycle 155±1, char_data=0x41, frame_error=0, overrun=0.
REQ-030 Pulse rx_serial low for 4 cycles, then hold high -> FSM returns to IDLE; no output changes.
REQ-031 Send 0x55 with the stop bit low -> frame_error=1, char_received=0, char_data unchanged; rx_ack=1 then clears frame_error.
REQ-032 Send 0x12 then 0x34 without rx_ack -> char_data=0x34, char_received=1, overrun=1; one rx_ack cycle clears both flags and char_data stays 0x34.
REQ-033 Assert rx_ack in the exact completion cycle of 0xA5 -> char_received=1, char_data=0xA5, overrun=0.
REQ-034 Assert reset_n=0 during bit 4 of 0xFF, release, then send 0x0F -> no flag for the aborted frame; 0x0F is received correctly.
